ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, for example 0xED (set LEDs), 0xFF (reset) and 0xF4 (enable).
- Sits beside ps2_key on the same ps2_clk/ps2_data pair and drives both lines open-drain.
- Implements the full host-request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, device ACK.
- Asserts busy so the receive path can be gated off during transmission.

---
 rtl/ps2_host_tx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Runs the host-request sequence (clock inhibit,
// start bit, 8 data bits LSB first, odd parity, stop bit, device ACK) on an
// open-drain ps2_clk/ps2_data pair. It shares the lines with the receiver, which
// can use busy to gate itself off while a transfer is in progress.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam logic [CNT_WIDTH-1:0] InhibitLast = CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StShift,
    StAck,
    StWaitIdle
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [8:0]           shift_q, shift_d;
  logic                 ack_bad_q, ack_bad_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q, done_d;
  logic                 ack_err_q, ack_err_d;
  logic                 timeout_err_q, timeout_err_d;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fall;
  logic timeout_hit;

  // Two-flop synchronizers on both lines plus one extra stage for edge detection.
  // Reset to the idle-high level so leaving reset cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign fall        = clk_prev & ~clk_sync;
  assign timeout_hit = (cnt_q == TimeoutLast);

  // State, counters and registered line/status outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      ack_bad_q     <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      ack_bad_q     <= ack_bad_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic for the host-request sequence; timeout beats a same-cycle fall.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    ack_bad_d     = ack_bad_q;
    data_oe_d     = data_oe_q;
    done_d        = 1'b0;
    ack_err_d     = 1'b0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shift_d   = {~^tx_data, tx_data};
          ack_bad_d = 1'b0;
          state_d   = StInhibit;
        end
      end

      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = StStart;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StStart: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = StShift;
      end

      StShift: begin
        if (timeout_hit) begin
          cnt_d         = '0;
          data_oe_d     = 1'b0;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else if (fall) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            // Stop bit: release data and let the pull-up drive it high.
            data_oe_d = 1'b0;
            state_d   = StAck;
          end else begin
            data_oe_d = ~shift_q[bit_cnt_q];
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StAck: begin
        if (timeout_hit) begin
          cnt_d         = '0;
          data_oe_d     = 1'b0;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else if (fall) begin
          cnt_d     = '0;
          ack_bad_d = data_sync;
          state_d   = StWaitIdle;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StWaitIdle: begin
        if (timeout_hit) begin
          cnt_d         = '0;
          data_oe_d     = 1'b0;
          done_d        = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else if (clk_sync && data_sync) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          ack_err_d = ack_bad_q;
          state_d   = StIdle;
        end else if (fall) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      default: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end
    endcase

    // Clock is pulled low only while inhibiting or presenting the start bit.
    clk_oe_d = (state_d == StInhibit) || (state_d == StStart);
  end

  assign tx_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned Inhibit = 20;
  localparam int unsigned Timeout = 400;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_line, data_line;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  // Open-drain wired-AND of host and device.
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inhibit),
    .TIMEOUT_CYCLES(Timeout),
    .CNT_WIDTH     (20)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (clk_line),
    .ps2_data_i (data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Count done pulses; error flags must stay low whenever done is low.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
    end else begin
      n_cmp++;
      assert ({ack_err, timeout_err} === 2'b00)
      else begin
        n_err++;
        $error("FAIL flags_without_done: observed %b expected 00", {ack_err, timeout_err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it: {stop, odd parity, data}.
  function automatic logic [9:0] frame(input logic [7:0] b);
    int ones = 0;
    logic par;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  // Called at the sample right after accept: measures clock inhibit, start bit, release.
  task automatic inhibit_phase(input string tag);
    int n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_inhibit_len"}, 32'(n), 32'(Inhibit));
    chk({tag, "_start_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'h3);
    tick();
    chk({tag, "_release_oe"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'h1);
  endtask

  // Device: clocks nfall falling edges, samples data late in each low phase,
  // optionally drives ACK low for the 11th edge, then releases both lines.
  task automatic dev_run(input int half, input int nfall, input bit ack,
                         output logic [9:0] bits);
    bits = '0;
    chk("start_bit_low", 32'(data_line), 32'h0);
    repeat (half) tick();
    for (int i = 0; i < nfall; i++) begin
      dev_clk_low = 1'b1;
      repeat (half) tick();
      if (i < 10) bits[i] = data_line;
      dev_clk_low = 1'b0;
      if (i == 10) dev_data_low = 1'b0;
      if (i == 9 && ack) dev_data_low = 1'b1;
      if (i < 10) repeat (half) tick();
    end
  endtask

  task automatic wait_done(input string tag, input bit exp_ack, input bit exp_to);
    int n = 0;
    while (done !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'h1);
    chk({tag, "_err_flags"}, 32'({ack_err, timeout_err}), 32'({exp_ack, exp_to}));
    chk({tag, "_oe_at_done"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
    chk({tag, "_ready_at_done"}, 32'(tx_ready), 32'h1);
  endtask

  task automatic post_done(input string tag);
    tick();
    chk({tag, "_done_single"}, 32'(done), 32'h0);
    chk({tag, "_busy_after"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [9:0] bits;
    int d0;
    int n;
    logic [7:0] b;
    int half;
    bit ack;

    repeat (3) tick();
    chk("rst_ready", 32'(tx_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rstn = 1'b1;
    tick();

    // Basic 0xED transfer.
    tx_data = 8'hED;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ed_ready_drop", 32'(tx_ready), 32'h0);
    chk("ed_busy", 32'(busy), 32'h1);
    inhibit_phase("ed");
    dev_run(30, 11, 1'b1, bits);
    chk("ed_bits", 32'(bits), 32'h3ED);
    wait_done("ed", 1'b0, 1'b0);
    post_done("ed");

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    d0 = done_cnt;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    inhibit_phase("b2b0");
    dev_run(30, 11, 1'b1, bits);
    chk("b2b0_bits", 32'(bits), 32'h300);
    wait_done("b2b0", 1'b0, 1'b0);
    tick();
    tx_valid = 1'b0;
    chk("b2b1_busy", 32'(busy), 32'h1);
    chk("b2b1_clk_oe", 32'(ps2_clk_oe), 32'h1);
    inhibit_phase("b2b1");
    dev_run(30, 11, 1'b1, bits);
    chk("b2b1_bits", 32'(bits), 32'h3FF);
    wait_done("b2b1", 1'b0, 1'b0);
    post_done("b2b1");
    chk("b2b_done_count", 32'(done_cnt - d0), 32'h2);

    // Device never clocks: timeout measured from clock release.
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    inhibit_phase("to");
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'(Timeout));
    wait_done("to", 1'b0, 1'b1);
    post_done("to");

    // Missing ACK on 0x01.
    tx_data = 8'h01;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    inhibit_phase("nack");
    dev_run(25, 11, 1'b0, bits);
    chk("nack_bits", 32'(bits), 32'h201);
    wait_done("nack", 1'b1, 1'b0);
    post_done("nack");

    // Reset in SHIFT after four edges, then a clean 0xF4.
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    inhibit_phase("rst");
    dev_run(20, 4, 1'b1, bits);
    d0 = done_cnt;
    rstn = 1'b0;
    tick();
    chk("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_ready", 32'(tx_ready), 32'h1);
    chk("rst_mid_done", 32'(done), 32'h0);
    rstn = 1'b1;
    repeat (5) tick();
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'h0);
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    inhibit_phase("f4");
    dev_run(30, 11, 1'b1, bits);
    chk("f4_bits", 32'(bits), 32'h2F4);
    wait_done("f4", 1'b0, 1'b0);
    post_done("f4");

    // 0xAA offered while busy must not disturb 0xED.
    tx_data = 8'hED;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    inhibit_phase("aa");
    tx_data = 8'hAA;
    tx_valid = 1'b1;
    repeat (3) tick();
    tx_valid = 1'b0;
    dev_run(30, 11, 1'b1, bits);
    chk("aa_bits", 32'(bits), 32'h3ED);
    wait_done("aa", 1'b0, 1'b0);
    post_done("aa");
    repeat (5) tick();
    chk("aa_not_started", 32'(busy), 32'h0);

    // Random bytes, device speeds and ACK behaviour against the frame model.
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      half = int'($urandom_range(8, 40));
      ack = 1'($urandom_range(0, 1));
      tx_data = b;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      inhibit_phase("rnd");
      dev_run(half, 11, ack, bits);
      chk("rnd_bits", 32'(bits), 32'(frame(b)));
      wait_done("rnd", ~ack, 1'b0);
      post_done("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
